// File: rtl/axi2per_per_arbiter.sv
// Round-robin arbiter sharing one single-outstanding peripheral port between
// NUM_REQ bridges; the response is steered back to the granted requester.
module axi2per_per_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [NUM_REQ-1:0]                      slv_req_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]      slv_add_i,
  input  logic [NUM_REQ-1:0]                      slv_we_i,
  input  logic [NUM_REQ-1:0][5:0]                 slv_atop_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]      slv_wdata_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]    slv_be_i,
  output logic [NUM_REQ-1:0]                      slv_gnt_o,
  output logic [NUM_REQ-1:0]                      slv_r_valid_o,
  output logic [DATA_WIDTH-1:0]                   slv_r_rdata_o,
  output logic                                    slv_r_opc_o,
  output logic                                    mst_req_o,
  output logic [ADDR_WIDTH-1:0]                   mst_add_o,
  output logic                                    mst_we_o,
  output logic [5:0]                              mst_atop_o,
  output logic [DATA_WIDTH-1:0]                   mst_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                 mst_be_o,
  input  logic                                    mst_gnt_i,
  input  logic                                    mst_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                   mst_r_rdata_i,
  input  logic                                    mst_r_opc_i,
  output logic                                    busy_o
);

  localparam int IDX_WIDTH = $clog2(NUM_REQ);

  typedef enum logic [1:0] {Idle, Hold, Pending} state_e;

  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] rr_q, rr_d, sel_q, sel_d;
  logic [IDX_WIDTH-1:0] win, sel;
  logic                 win_vld, req;
  int                   idx;

  // Search rr_q, rr_q+1, ... with explicit wrap so NUM_REQ need not be 2^n.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_vld && slv_req_i[idx]) begin
        win_vld = 1'b1;
        win     = IDX_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    sel_d         = sel_q;
    sel           = sel_q;
    req           = 1'b0;
    slv_gnt_o     = '0;
    slv_r_valid_o = '0;
    busy_o        = 1'b0;
    case (state_q)
      Idle: begin
        req = win_vld;
        sel = win;
      end
      Hold: begin
        // Locked selection: a later higher-priority request cannot preempt.
        req = slv_req_i[sel_q];
        if (!req) state_d = Idle;
      end
      Pending: begin
        busy_o               = 1'b1;
        slv_r_valid_o[sel_q] = mst_r_valid_i;
        if (mst_r_valid_i) state_d = Idle;
      end
      default: state_d = Idle;
    endcase
    if (req) begin
      sel_d = sel;
      if (mst_gnt_i) begin
        slv_gnt_o[sel] = 1'b1;
        rr_d           = (sel == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
        state_d        = Pending;
      end else begin
        state_d = Hold;
      end
    end
  end

  assign mst_req_o     = req;
  assign mst_add_o     = req ? slv_add_i[sel]   : '0;
  assign mst_we_o      = req & slv_we_i[sel];
  assign mst_atop_o    = req ? slv_atop_i[sel]  : '0;
  assign mst_wdata_o   = req ? slv_wdata_i[sel] : '0;
  assign mst_be_o      = req ? slv_be_i[sel]    : '0;
  assign slv_r_rdata_o = mst_r_rdata_i;
  assign slv_r_opc_o   = mst_r_opc_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      rr_q    <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
    end
  end

  // A response outside Pending must never reach a requester.
  always_ff @(posedge clk_i) begin
    if (rst_ni && state_q != Pending) assert (slv_r_valid_o == '0);
  end

endmodule

// File: tb/tb_axi2per_per_arbiter.sv
// Directed + random bench for axi2per_per_arbiter (NUM_REQ=3) against a
// behavioural round-robin model held in plain integers.
module tb_axi2per_per_arbiter;
  localparam int N = 3;
  localparam int S_IDLE = 0, S_HOLD = 1, S_PEND = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]       req, we;
  logic [N-1:0][31:0] add, wdata;
  logic [N-1:0][5:0]  atop;
  logic [N-1:0][3:0]  be;
  logic               mgnt, mrv, mopc;
  logic [31:0]        mrdata;
  logic [N-1:0]       gnt, rv;
  logic [31:0]        rdata, madd, mwdata;
  logic               opc, mreq, mwe, busy;
  logic [5:0]         matop;
  logic [3:0]         mbe;

  int n_cmp = 0, n_err = 0;
  int m_st, m_rr, m_sel, n_st, n_rr, n_sel;
  logic e_req, e_busy;
  int e_idx;
  logic [N-1:0] e_gnt, e_rv;
  bit rec = 0;
  int cyc = 0;
  int g_idx[$], g_cyc[$];

  always #5 clk = ~clk;

  axi2per_per_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_req_i(req), .slv_add_i(add), .slv_we_i(we), .slv_atop_i(atop),
    .slv_wdata_i(wdata), .slv_be_i(be),
    .slv_gnt_o(gnt), .slv_r_valid_o(rv), .slv_r_rdata_o(rdata), .slv_r_opc_o(opc),
    .mst_req_o(mreq), .mst_add_o(madd), .mst_we_o(mwe), .mst_atop_o(matop),
    .mst_wdata_o(mwdata), .mst_be_o(mbe),
    .mst_gnt_i(mgnt), .mst_r_valid_i(mrv), .mst_r_rdata_i(mrdata), .mst_r_opc_i(mopc),
    .busy_o(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: one transaction at a time, priority list starts at the pointer.
  task automatic eval();
    e_req = 0; e_idx = 0; e_gnt = '0; e_rv = '0; e_busy = 0;
    n_st = m_st; n_rr = m_rr; n_sel = m_sel;
    case (m_st)
      S_PEND: begin
        e_busy = 1;
        if (mrv) begin e_rv[m_sel] = 1; n_st = S_IDLE; end
      end
      S_HOLD: begin
        e_idx = m_sel;
        e_req = req[m_sel];
        if (!e_req) n_st = S_IDLE;
      end
      default:
        for (int k = 0; k < N; k++)
          if (!e_req && req[(m_rr + k) % N]) begin e_req = 1; e_idx = (m_rr + k) % N; end
    endcase
    if (e_req) begin
      n_sel = e_idx;
      if (mgnt) begin e_gnt[e_idx] = 1; n_rr = (e_idx + 1) % N; n_st = S_PEND; end
      else n_st = S_HOLD;
    end
  endtask

  task automatic compare();
    check("mst_req", 64'(mreq), 64'(e_req));
    check("mst_add", 64'(madd), e_req ? 64'(add[e_idx]) : 64'h0);
    check("mst_we", 64'(mwe), e_req ? 64'(we[e_idx]) : 64'h0);
    check("mst_atop", 64'(matop), e_req ? 64'(atop[e_idx]) : 64'h0);
    check("mst_wdata", 64'(mwdata), e_req ? 64'(wdata[e_idx]) : 64'h0);
    check("mst_be", 64'(mbe), e_req ? 64'(be[e_idx]) : 64'h0);
    check("slv_gnt", 64'(gnt), 64'(e_gnt));
    check("slv_r_valid", 64'(rv), 64'(e_rv));
    check("busy", 64'(busy), 64'(e_busy));
    check("rdata", 64'(rdata), 64'(mrdata));
    check("opc", 64'(opc), 64'(mopc));
  endtask

  // Inputs are set at posedge+1; outputs sampled mid-cycle; model steps on the edge.
  task automatic cycle();
    #3;
    eval();
    compare();
    if (rec) for (int j = 0; j < N; j++)
      if (gnt[j]) begin g_idx.push_back(j); g_cyc.push_back(cyc); end
    @(posedge clk);
    m_st = n_st; m_rr = n_rr; m_sel = n_sel;
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_st = S_IDLE; m_rr = 0; m_sel = 0;
    #1;
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_mst_req", 64'(mreq), 64'h0);
    check("rst_mst_add", 64'(madd), 64'h0);
    check("rst_gnt", 64'(gnt), 64'h0);
    check("rst_rv", 64'(rv), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic clr();
    req = '0; we = '0; add = '0; wdata = '0; atop = '0; be = '0;
    mgnt = 0; mrv = 0; mopc = 0; mrdata = '0;
  endtask

  initial begin
    clr();
    do_reset();

    // single read
    req[0] = 1; add[0] = 32'h1000_0010; we[0] = 1; mgnt = 1;
    #2; check("sr_req", 64'(mreq), 64'h1); check("sr_add", 64'(madd), 64'h1000_0010);
    check("sr_gnt", 64'(gnt), 64'b001);
    cycle();
    req[0] = 0;
    #2; check("sr_busy", 64'(busy), 64'h1);
    cycle();
    mrv = 1; mrdata = 32'hDEAD_BEEF;
    #2; check("sr_rv", 64'(rv), 64'b001); check("sr_rdata", 64'(rdata), 64'hDEAD_BEEF);
    cycle();
    clr();

    // round-robin fairness, one-cycle response latency
    do_reset();
    req = 3'b111; mgnt = 1; mrv = 1; rec = 1; cyc = 0;
    repeat (12) cycle();
    rec = 0; clr();
    check("fair_cnt", 64'(g_idx.size()), 64'd6);
    for (int k = 0; k < 6 && k < g_idx.size(); k++) begin
      check("fair_order", 64'(g_idx[k]), 64'(k % 3));
      if (k > 0) check("fair_gap", 64'(g_cyc[k] - g_cyc[k-1]), 64'd2);
    end

    // hold lock
    do_reset();
    add[1] = 32'hAAAA_1111; add[0] = 32'h0000_0F00; req = 3'b010;
    #2; check("hold_add0", 64'(madd), 64'hAAAA_1111);
    cycle();
    req = 3'b011;
    #2; check("hold_add1", 64'(madd), 64'hAAAA_1111);
    cycle();
    #2; check("hold_add2", 64'(madd), 64'hAAAA_1111);
    cycle();
    mgnt = 1;
    #2; check("hold_gnt", 64'(gnt), 64'b010);
    cycle();
    mrv = 1; req = 3'b001;
    cycle();
    mrv = 0;
    #2; check("hold_next", 64'(gnt), 64'b001);
    cycle();
    mrv = 1; req = '0;
    cycle();
    clr();

    // atomic write pass-through
    do_reset();
    req = 3'b010; we[1] = 0; atop[1] = 6'h0B; wdata[1] = 32'h5; be[1] = 4'hF;
    add[1] = 32'h2000_0004; mgnt = 1;
    #2; check("at_we", 64'(mwe), 64'h0); check("at_atop", 64'(matop), 64'h0B);
    check("at_wdata", 64'(mwdata), 64'h5); check("at_be", 64'(mbe), 64'hF);
    check("at_gnt", 64'(gnt), 64'b010);
    cycle();
    req = '0; mrv = 1; mopc = 1;
    #2; check("at_rv", 64'(rv), 64'b010); check("at_opc", 64'(opc), 64'h1);
    cycle();
    clr();

    // reset mid-pending
    do_reset();
    req = 3'b001; mgnt = 1;
    cycle();
    req = '0;
    #2; check("rp_busy", 64'(busy), 64'h1);
    do_reset();
    clr(); req = 3'b011; mgnt = 1;
    #2; check("rp_prio0", 64'(gnt), 64'b001);
    cycle();
    req = '0; mrv = 1;
    cycle();
    clr();
    do_reset();
    req = 3'b010; mgnt = 1;
    #2; check("rp_prio1", 64'(gnt), 64'b010);
    cycle();
    req = '0; mrv = 1;
    cycle();
    clr();

    // stray response in Idle
    do_reset();
    mrv = 1;
    #2; check("stray_rv", 64'(rv), 64'h0); check("stray_busy", 64'(busy), 64'h0);
    cycle();
    req = 3'b001; mgnt = 1;
    #2; check("stray_idle_gnt", 64'(gnt), 64'b001);
    cycle();
    clr();

    // randomized traffic against the model
    do_reset();
    repeat (400) begin
      req = N'($urandom);
      we = N'($urandom);
      for (int j = 0; j < N; j++) begin
        add[j] = $urandom; wdata[j] = $urandom;
        atop[j] = 6'($urandom); be[j] = 4'($urandom);
      end
      mgnt = 1'($urandom);
      mrv = ($urandom_range(0, 3) != 0);
      mopc = 1'($urandom);
      mrdata = $urandom;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
